elevator_controller: RTL and testbench

Three-floor (0–2) elevator controller: latches hall calls and cab selections, moves the car one floor per travel interval, opens the door for a fixed dwell at requested floors, and optionally homes to floor 0 when idle. Sits between debounced single-clock button inputs and the motor/door/indicator drivers. All timing is counted in clock cycles.

---
 rtl/elevator_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_elevator_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
// elevator_controller
//   Three-floor (0..2) elevator controller. Latches hall calls and cab
//   selections into a pending mask, moves the car one floor per
//   TRAVEL_CYCLES, holds the door open DOOR_CYCLES per stop, and parks.
//
//   Optional feature macro: HOME_RETURN_EN
//     defined   -> after HOME_DELAY_CYCLES idle cycles away from floor 0 with
//                  nothing pending, the car travels down to floor 0 (door shut)
//     undefined -> the car parks at its last floor
//
//   Ports
//     clk                          system clock, rising edge
//     rst                          asynchronous reset, active low
//     call_up_0, call_up_1         hall up-calls (floors 0, 1)
//     call_down_1, call_down_2     hall down-calls (floors 1, 2)
//     select_floor_0/1/2           cab selections
//     current_floor[1:0]           car position 0..2
//     door_open                    door open (registered)
//     moving_up, moving_down       motor direction (registered)
module elevator_controller #(
  parameter int unsigned TRAVEL_CYCLES     = 50_000_000,
  parameter int unsigned DOOR_CYCLES       = 30_000_000,
  parameter int unsigned HOME_DELAY_CYCLES = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_up_0,
  input  logic       call_up_1,
  input  logic       call_down_1,
  input  logic       call_down_2,
  input  logic       select_floor_0,
  input  logic       select_floor_1,
  input  logic       select_floor_2,
  output logic [1:0] current_floor,
  output logic       door_open,
  output logic       moving_up,
  output logic       moving_down
);

  localparam int unsigned MAX_TD  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_TD > HOME_DELAY_CYCLES) ? MAX_TD : HOME_DELAY_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_CYCLES - 1);

  if (TRAVEL_CYCLES < 2) begin : g_bad_travel
    $error("TRAVEL_CYCLES must be >= 2");
  end
  if (DOOR_CYCLES < 1) begin : g_bad_door
    $error("DOOR_CYCLES must be >= 1");
  end
  if (HOME_DELAY_CYCLES < 1) begin : g_bad_home
    $error("HOME_DELAY_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       floor_q, floor_d;
  logic [2:0]       pending_q, pending_d;
  logic             dir_up_q, dir_up_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             door_q, door_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;

  logic [2:0] req;
  logic [1:0] floor_up, floor_dn;
  logic       home_cont;

  function automatic logic at_floor(input logic [1:0] f, input logic [2:0] p);
    case (f)
      2'd0:    return p[0];
      2'd1:    return p[1];
      2'd2:    return p[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic req_above(input logic [1:0] f, input logic [2:0] p);
    case (f)
      2'd0:    return p[1] | p[2];
      2'd1:    return p[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic req_below(input logic [1:0] f, input logic [2:0] p);
    case (f)
      2'd1:    return p[0];
      2'd2:    return p[0] | p[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Hall direction is deliberately folded into the per-floor request.
  assign req = {call_down_2 | select_floor_2,
                call_up_1 | call_down_1 | select_floor_1,
                call_up_0 | select_floor_0};

  assign floor_up = floor_q + 2'd1;
  assign floor_dn = floor_q - 2'd1;

`ifdef HOME_RETURN_EN
  logic home_q, home_d;

  // A home trip keeps descending through empty floors only while nothing
  // else is pending; any new request hands control back to the normal rules.
  assign home_cont = home_q && (pending_q == 3'b000) && (floor_dn != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) home_q <= 1'b0;
    else      home_q <= home_d;
  end
`else
  assign home_cont = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      floor_q   <= 2'd0;
      pending_q <= 3'b000;
      dir_up_q  <= 1'b1;
      tmr_q     <= '0;
      door_q    <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_up_q  <= dir_up_d;
      tmr_q     <= tmr_d;
      door_q    <= door_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    tmr_d     = '0;
    pending_d = pending_q | req;
`ifdef HOME_RETURN_EN
    home_d    = home_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (at_floor(floor_q, pending_q)) begin
          state_d = DOOR_OPEN;
        end else if (dir_up_q && req_above(floor_q, pending_q)) begin
          state_d = MOVE_UP;
        end else if (!dir_up_q && req_below(floor_q, pending_q)) begin
          state_d = MOVE_DOWN;
        end else if (req_above(floor_q, pending_q)) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end else if (req_below(floor_q, pending_q)) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
        end else begin
`ifdef HOME_RETURN_EN
          // Nothing pending here: the timer doubles as the idle counter.
          if (floor_q != 2'd0) begin
            if (tmr_q == TMR_W'(HOME_DELAY_CYCLES - 1)) begin
              state_d  = MOVE_DOWN;
              dir_up_d = 1'b0;
              home_d   = 1'b1;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
`endif
        end
      end
      MOVE_UP: begin
        if (tmr_q == TRAVEL_LAST) begin
          floor_d = floor_up;
          if (at_floor(floor_up, pending_q))       state_d = DOOR_OPEN;
          else if (req_above(floor_up, pending_q)) state_d = MOVE_UP;
          else                                     state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (tmr_q == TRAVEL_LAST) begin
          floor_d = floor_dn;
          if (at_floor(floor_dn, pending_q))                    state_d = DOOR_OPEN;
          else if (req_below(floor_dn, pending_q) || home_cont) state_d = MOVE_DOWN;
          else                                                  state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DOOR_OPEN: begin
        // The current floor is being served, so its request never latches;
        // a fresh press instead restarts the dwell.
        pending_d = pending_d & ~onehot(floor_q);
        if (at_floor(floor_q, req)) tmr_d = '0;
        else if (tmr_q == DOOR_LAST) state_d = IDLE;
        else tmr_d = tmr_q + 1'b1;
      end
    endcase
`ifdef HOME_RETURN_EN
    if (state_d != MOVE_DOWN) home_d = 1'b0;
`endif
  end

  // Outputs decode the next state so they change on the same edge as it.
  always_comb begin
    door_d = (state_d == DOOR_OPEN);
    up_d   = (state_d == MOVE_UP);
    dn_d   = (state_d == MOVE_DOWN);
  end

  assign current_floor = floor_q;
  assign door_open     = door_q;
  assign moving_up     = up_q;
  assign moving_down   = dn_q;

endmodule

// File: tb/tb_elevator_controller.sv
module tb_elevator_controller;

  localparam int T = 10;
  localparam int D = 5;
  localparam int H = 8;

`ifdef HOME_RETURN_EN
  localparam bit HOME_EN = 1'b1;
`else
  localparam bit HOME_EN = 1'b0;
`endif

  // btn bit order: cu0, cu1, cd1, cd2, sel0, sel1, sel2
  localparam logic [6:0] CU1  = 7'b0000010;
  localparam logic [6:0] CD2  = 7'b0001000;
  localparam logic [6:0] SEL0 = 7'b0010000;
  localparam logic [6:0] SEL1 = 7'b0100000;
  localparam logic [6:0] SEL2 = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] btn = '0;
  logic [1:0] current_floor;
  logic       door_open, moving_up, moving_down;

  always #5 clk = ~clk;

  elevator_controller #(
    .TRAVEL_CYCLES(T),
    .DOOR_CYCLES(D),
    .HOME_DELAY_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .call_up_0(btn[0]),
    .call_up_1(btn[1]),
    .call_down_1(btn[2]),
    .call_down_2(btn[3]),
    .select_floor_0(btn[4]),
    .select_floor_1(btn[5]),
    .select_floor_2(btn[6]),
    .current_floor(current_floor),
    .door_open(door_open),
    .moving_up(moving_up),
    .moving_down(moving_down)
  );

  typedef struct {
    int         cyc;
    logic [4:0] val;   // {floor[1:0], door, up, down}
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [4:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output changes are scheduled by cycle; anything else that moves is wrong.
  always @(negedge clk) begin : monitor
    logic [4:0] cur;
    exp_t       x;
    if (mon_en) begin
      cur = {current_floor, door_open, moving_up, moving_down};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        x = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event cyc=%0d actual none required %b", x.cyc, x.val);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        x = exp_q.pop_front();
        checks++;
        if (cur !== x.val) begin
          errors++;
          $display("FAIL event cyc=%0d actual {fl,door,up,dn}=%b required %b", cyc, cur, x.val);
        end
      end else if (cur !== prev) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change cyc=%0d actual %b required %b", cyc, cur, prev);
      end
      prev = cur;
    end
  end

  task automatic push(input int c, input logic [1:0] f, input logic d, input logic u, input logic n);
    exp_t x;
    x.cyc = c;
    x.val = {f, d, u, n};
    exp_q.push_back(x);
  endtask

  // Button mask is sampled by the rising edge numbered e.
  task automatic pulse_at(input int e, input logic [6:0] m);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
    #1 btn = m;
    @(posedge clk);
    #1;
    #1 btn = '0;
  endtask

  // Home trip that follows an idle car parked at floor f from edge t.
  task automatic home_tail(input logic [1:0] f, input int t);
    if (HOME_EN) begin
      if (f == 2'd2) begin
        push(t + 8,  2'd2, 1'b0, 1'b0, 1'b1);
        push(t + 18, 2'd1, 1'b0, 1'b0, 1'b1);
        push(t + 28, 2'd0, 1'b0, 1'b0, 1'b0);
      end else if (f == 2'd1) begin
        push(t + 8,  2'd1, 1'b0, 1'b0, 1'b1);
        push(t + 18, 2'd0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      g++;
      if (g > 1000) begin
        $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
        $fatal(1, "scoreboard did not drain");
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Car at 2 going to 0, optionally restarting the dwell at floor 0.
  task automatic down_to_0(input bit restart);
    int e;
    e = cyc + 2;
    pulse_at(e, SEL0);
    push(e + 1,  2'd2, 1'b0, 1'b0, 1'b1);
    push(e + 11, 2'd1, 1'b0, 1'b0, 1'b1);
    push(e + 21, 2'd0, 1'b1, 1'b0, 1'b0);
    if (restart) begin
      push(e + 28, 2'd0, 1'b0, 1'b0, 1'b0);
      pulse_at(e + 23, SEL0);
    end else begin
      push(e + 26, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    drain();
  endtask

  initial begin : stim
    int e;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    push(cyc + 1, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    #1 rst = 1'b1;
    drain();

    // select_floor_2 from floor 0: pass floor 1, stop at 2
    e = cyc + 2;
    pulse_at(e, SEL2);
    push(e + 1,  2'd0, 1'b0, 1'b1, 1'b0);
    push(e + 11, 2'd1, 1'b0, 1'b1, 1'b0);
    push(e + 21, 2'd2, 1'b1, 1'b0, 1'b0);
    push(e + 26, 2'd2, 1'b0, 1'b0, 1'b0);
    home_tail(2'd2, e + 26);
    drain();

    if (!HOME_EN) down_to_0(1'b0);

    // call_up_1 from floor 0, select_floor_2 during the dwell at 1
    e = cyc + 2;
    pulse_at(e, CU1);
    push(e + 1,  2'd0, 1'b0, 1'b1, 1'b0);
    push(e + 11, 2'd1, 1'b1, 1'b0, 1'b0);
    push(e + 16, 2'd1, 1'b0, 1'b0, 1'b0);
    push(e + 17, 2'd1, 1'b0, 1'b1, 1'b0);
    push(e + 27, 2'd2, 1'b1, 1'b0, 1'b0);
    push(e + 32, 2'd2, 1'b0, 1'b0, 1'b0);
    home_tail(2'd2, e + 32);
    pulse_at(e + 13, SEL2);
    drain();

    // Back to 0 with a dwell restart from the current-floor button
    if (!HOME_EN) down_to_0(1'b1);

    // call_down_2 from floor 0, then select_floor_0 after the dwell
    e = cyc + 2;
    pulse_at(e, CD2);
    push(e + 1,  2'd0, 1'b0, 1'b1, 1'b0);
    push(e + 11, 2'd1, 1'b0, 1'b1, 1'b0);
    push(e + 21, 2'd2, 1'b1, 1'b0, 1'b0);
    push(e + 26, 2'd2, 1'b0, 1'b0, 1'b0);
    home_tail(2'd2, e + 26);
    drain();
    if (!HOME_EN) down_to_0(1'b0);

    // Idle at 1 after moving up: requests above and below together, up wins
    e = cyc + 2;
    pulse_at(e, SEL1);
    push(e + 1,  2'd0, 1'b0, 1'b1, 1'b0);
    push(e + 11, 2'd1, 1'b1, 1'b0, 1'b0);
    push(e + 16, 2'd1, 1'b0, 1'b0, 1'b0);
    push(e + 19, 2'd1, 1'b0, 1'b1, 1'b0);
    push(e + 29, 2'd2, 1'b1, 1'b0, 1'b0);
    push(e + 34, 2'd2, 1'b0, 1'b0, 1'b0);
    push(e + 35, 2'd2, 1'b0, 1'b0, 1'b1);
    push(e + 45, 2'd1, 1'b0, 1'b0, 1'b1);
    push(e + 55, 2'd0, 1'b1, 1'b0, 1'b0);
    push(e + 60, 2'd0, 1'b0, 1'b0, 1'b0);
    pulse_at(e + 18, SEL0 | SEL2);
    drain();

    // Reset mid-travel between floors 1 and 2; the old request must vanish
    e = cyc + 2;
    pulse_at(e, SEL2);
    push(e + 1,  2'd0, 1'b0, 1'b1, 1'b0);
    push(e + 11, 2'd1, 1'b0, 1'b1, 1'b0);
    push(e + 13, 2'd0, 1'b0, 1'b0, 1'b0);
    while (cyc < e + 13) begin
      @(posedge clk);
      #1;
    end
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    drain();
    repeat (30) @(posedge clk);
    #1;

    // Normal service after reset
    e = cyc + 2;
    pulse_at(e, SEL1);
    push(e + 1,  2'd0, 1'b0, 1'b1, 1'b0);
    push(e + 11, 2'd1, 1'b1, 1'b0, 1'b0);
    push(e + 16, 2'd1, 1'b0, 1'b0, 1'b0);
    home_tail(2'd1, e + 16);
    drain();

    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
